// File: rtl/addsub_pkg.sv
// Shared types and the combinational add/subtract/saturate function for addsub_pipe.
package addsub_pkg;

  typedef enum logic [1:0] {
    SAT_WRAP     = 2'd0,
    SAT_UNSIGNED = 2'd1,
    SAT_SIGNED   = 2'd2
  } sat_mode_e;

  // Widest operand the calculation function supports; WIDTH must not exceed it.
  localparam int MAX_WIDTH = 64;

  typedef struct packed {
    logic [MAX_WIDTH-1:0] result;
    logic                 carry;
    logic                 overflow;
  } calc_t;

  // Operands are zero-extended to MAX_WIDTH; 'width' selects the active low bits.
  // Bit positions are picked with masks instead of variable indices so the
  // function stays width-agnostic.
  function automatic calc_t addsub_calc(input logic [MAX_WIDTH-1:0] a,
                                        input logic [MAX_WIDTH-1:0] b,
                                        input logic                 op,
                                        input sat_mode_e            mode,
                                        input int unsigned          width);
    logic [MAX_WIDTH-1:0] mask;
    logic [MAX_WIDTH-1:0] smax;
    logic [MAX_WIDTH-1:0] smin;
    logic [MAX_WIDTH-1:0] am;
    logic [MAX_WIDTH-1:0] bm;
    logic [MAX_WIDTH-1:0] r;
    logic [MAX_WIDTH:0]   sum;
    logic [MAX_WIDTH:0]   cbit;
    logic                 a_msb;
    logic                 b_msb;
    logic                 r_msb;
    calc_t                res;

    mask  = (MAX_WIDTH'(1) << width) - MAX_WIDTH'(1);
    smax  = mask >> 1;
    smin  = mask & ~smax;
    am    = a & mask;
    bm    = b & mask;
    if (op) begin
      sum = {1'b0, am} + {1'b0, bm};
    end else begin
      sum = {1'b0, am} - {1'b0, bm};
    end
    r     = sum[MAX_WIDTH-1:0] & mask;
    cbit  = {1'b0, mask} + {{MAX_WIDTH{1'b0}}, 1'b1};
    a_msb = |(am & smin);
    b_msb = |(bm & smin);
    r_msb = |(r & smin);

    res.carry    = op ? (|(sum & cbit)) : (am < bm);
    res.overflow = op ? ((a_msb == b_msb) && (r_msb != a_msb))
                      : ((a_msb != b_msb) && (r_msb != a_msb));

    case (mode)
      SAT_WRAP: begin
        res.result = r;
      end
      SAT_UNSIGNED: begin
        if (res.carry) begin
          res.result = op ? mask : {MAX_WIDTH{1'b0}};
        end else begin
          res.result = r;
        end
      end
      SAT_SIGNED: begin
        if (res.overflow) begin
          res.result = a_msb ? smin : smax;
        end else begin
          res.result = r;
        end
      end
      default: begin
        res.result = r;
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/addsub_pipe_slot.sv
// One valid/ready register slot; accepts when empty or when its content leaves.
module addsub_pipe_slot #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [DW-1:0] up_data,
  output logic          dn_valid,
  input  logic          dn_ready,
  output logic [DW-1:0] dn_data
);

  logic          valid_r;
  logic [DW-1:0] data_r;

  assign up_ready = !valid_r || dn_ready;
  assign dn_valid = valid_r;
  assign dn_data  = data_r;

  // Capture on upstream transfer, drop on downstream transfer, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= {DW{1'b0}};
    end else if (up_valid && up_ready) begin
      valid_r <= 1'b1;
      data_r  <= up_data;
    end else if (dn_ready) begin
      valid_r <= 1'b0;
    end
  end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract with carry/overflow flags, optional saturation and
// valid/ready on both sides. Results travel with the operands that made them.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int        WIDTH    = 8,
  parameter int        STAGES   = 2,
  parameter sat_mode_e SAT_MODE = SAT_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  input  logic             add_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic [WIDTH-1:0] opa_q,
  output logic [WIDTH-1:0] opb_q,
  output logic             op_q
);

  // Payload: {opa, opb, op, result, carry, overflow}
  localparam int PW = 3 * WIDTH + 3;

  calc_t           calc_s;
  logic            calc_unused_s;
  logic [PW-1:0]   payload_s;
  logic [PW-1:0]   out_data_s;

  // All arithmetic happens ahead of slot 0; later slots only move data.
  always_comb begin
    calc_s        = addsub_calc(MAX_WIDTH'(dataa), MAX_WIDTH'(datab), add_sub, SAT_MODE, WIDTH);
    calc_unused_s = ^calc_s;
    payload_s     = {dataa, datab, add_sub, calc_s.result[WIDTH-1:0], calc_s.carry, calc_s.overflow};
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic          up_valid_s;
    logic          up_ready_s;
    logic [PW-1:0] up_data_s;
    logic          dn_valid_s;
    logic          dn_ready_s;
    logic [PW-1:0] dn_data_s;

    if (k == 0) begin : g_first
      assign up_valid_s = in_valid;
      assign up_data_s  = payload_s;
    end else begin : g_mid
      assign up_valid_s = g_stage[k-1].dn_valid_s;
      assign up_data_s  = g_stage[k-1].dn_data_s;
    end

    if (k == STAGES - 1) begin : g_last
      assign dn_ready_s = out_ready;
    end else begin : g_next
      assign dn_ready_s = g_stage[k+1].up_ready_s;
    end

    addsub_pipe_slot #(.DW(PW)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .up_valid (up_valid_s),
      .up_ready (up_ready_s),
      .up_data  (up_data_s),
      .dn_valid (dn_valid_s),
      .dn_ready (dn_ready_s),
      .dn_data  (dn_data_s)
    );
  end

  assign in_ready   = g_stage[0].up_ready_s;
  assign out_valid  = g_stage[STAGES-1].dn_valid_s;
  assign out_data_s = g_stage[STAGES-1].dn_data_s;
  assign {opa_q, opb_q, op_q, result, carry, overflow} = out_data_s;

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
Parametrised, pipelined add/subtract unit with valid/ready handshakes on both sides. It is the successor to the single-register 8-bit add/sub block, and adds:
- configurable width and latency
- carry/borrow and signed-overflow flags
- selectable saturation
- backpressure
It returns each result together with the operands that produced it, so result/operand relations can be checked on a single output beat.

Parameters:
WIDTH, 8, operand and result width in bits (>=2)
STAGES, 2, pipeline depth and accept-to-output latency in cycles (>=1)
SAT_MODE, SAT_WRAP, result mode from addsub_pkg::sat_mode_e: SAT_WRAP, SAT_UNSIGNED, SAT_SIGNED

Ports:
clk  in  1  single clock, all state on posedge
rst  in  1  synchronous reset, active-high
in_valid  in  1  operands on dataa/datab/add_sub are valid
in_ready  out  1  block accepts input this cycle
dataa  in  WIDTH  operand A
datab  in  WIDTH  operand B
add_sub  in  1  1 = A+B, 0 = A-B
out_valid  out  1  result beat valid
out_ready  in  1  consumer accepts result this cycle
result  out  WIDTH  final (possibly saturated) result
carry  out  1  add: carry out of MSB; sub: borrow (A<B unsigned)
overflow  out  1  signed two's-complement overflow
opa_q  out  WIDTH  dataa of the transaction on result
opb_q  out  WIDTH  datab of the transaction on result
op_q  out  1  add_sub of the transaction on result

Behaviour:
Interface:
- One clock (clk); reset is synchronous and active-high (rst).

Reset:
- All stage valid bits clear.
- result, carry, overflow, opa_q, opb_q and op_q all clear to 0.
- out_valid is 0 in the cycle after rst is sampled high.
- in_ready is 1 once rst is low.
- Reset during operation discards all in-flight transactions; no stale beat appears afterwards.

Handshakes:
- Input transfer occurs when in_valid && in_ready.
- Output transfer occurs when out_valid && out_ready.
- While out_valid && !out_ready, every output is held stable.
- in_valid must not depend on in_ready.

Pipeline:
- STAGES slots; slot 0 takes input, slot STAGES-1 drives the outputs.
- Slot k loads from slot k-1 when slot k is empty or slot k is advancing. Bubbles collapse.
- in_ready = !valid[0] || advance[0], derived combinationally.
- A full pipeline with out_ready=1 accepts a new input in the same cycle.
- Latency: an accept at cycle t gives out_valid at t+STAGES when out_ready has been held at 1.
- Order is strictly preserved. Throughput is 1 beat per cycle.

Arithmetic:
- Computed combinationally from the input and captured into slot 0; later slots only carry data.
- add: {carry, r} = {1'b0,A} + {1'b0,B}.
- sub: r = A - B; carry = borrow = (A < B unsigned).
- overflow, add: A[MSB]==B[MSB] && r[MSB]!=A[MSB].
- overflow, sub: A[MSB]!=B[MSB] && r[MSB]!=A[MSB].
- Saturation by SAT_MODE:
  - SAT_WRAP: result = r.
  - SAT_UNSIGNED: add with carry gives all ones; sub with borrow gives 0.
  - SAT_SIGNED: on overflow, result = max positive (0111..1) if A[MSB]==0, else min negative (1000..0).
- carry and overflow always report the raw, unsaturated condition.

Invariant (for assertions):
- With out_valid, in SAT_WRAP, result == (op_q ? opa_q+opb_q : opa_q-opb_q) mod 2^WIDTH.

Decomposition:
addsub_pkg:
- sat_mode_e enum.
- Function addsub_calc(a, b, op, mode), returning a packed struct {result, carry, overflow}. It is shared with the bench scoreboard.

Sub-module addsub_pipe_slot:
- One handshaked register slot parametrised on payload width.
- Ports: clk, rst, up_valid, up_ready, up_data, dn_valid, dn_ready, dn_data.
- Instantiated STAGES times in a generate loop.

Test Plan:
1. WIDTH=8, STAGES=2, SAT_WRAP, out_ready=1. Accept A=1, B=1, add at cycle 0 -> out_valid at cycle 2 with result=2, carry=0, opa_q=1, opb_q=1. Never result=4.
2. A=200, B=100, add -> SAT_WRAP: result=44, carry=1. SAT_UNSIGNED: result=255, carry=1.
3. A=1, B=2, sub -> SAT_WRAP: result=255, carry=1. SAT_UNSIGNED: result=0, carry=1.
4. SAT_SIGNED cases:
   - 127+1 -> result=127, overflow=1. SAT_WRAP gives 128.
   - 0x80-1 -> result=0x80, overflow=1. SAT_WRAP gives 0x7F.
5. Backpressure: stream 4 adds (1+1, 2+2, 3+3, 4+4) with out_ready=0 for 4 cycles ->
   - in_ready drops after 2 accepts.
   - result holds 2 while stalled.
   - After out_ready=1: outputs 2, 4, 6, 8 in order, one per cycle, no loss or duplication.
6. Full pipeline plus rst=1 for one cycle -> out_valid=0 and all outputs 0 the next cycle. The first post-reset input 5-3 yields result=2 after STAGES cycles.
